// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: stall/flush/freeze/drain control for the 5-stage core's pipeline registers and PC.
// Optional perf counters are built only when HAZARD_PERF_EN is defined; otherwise the counter ports read zero.
module hazard_ctrl #(
  parameter int REGW = 5,
  parameter int CNTW = 16
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            ihit,
  input  logic            dhit,
  input  logic [REGW-1:0] idrs,
  input  logic [REGW-1:0] idrt,
  input  logic [REGW-1:0] exwsel,
  input  logic            exMemToReg,
  input  logic            exBrTaken,
  input  logic            memcuDRE,
  input  logic            memcuDWE,
  input  logic            memcuHALT,
  output logic            pcW,
  output logic            ifW,
  output logic            idW,
  output logic            exW,
  output logic            memW,
  output logic            ifRST,
  output logic            idRST,
  output logic            exRST,
  output logic            memRST,
  output logic            halted,
  output logic [CNTW-1:0] stall_cnt,
  output logic [CNTW-1:0] flush_cnt,
  output logic [CNTW-1:0] dwait_cnt
);

  typedef enum logic [1:0] {RUN, DWAIT, DRAIN, HALTED} stateT;

  stateT state;
  stateT nextState;
  logic  dmemPend;
  logic  loadUse;

  assign dmemPend = (memcuDRE | memcuDWE) & ~dhit;
  // r0 is hardwired zero, so a load targeting it can never feed a dependent instruction
  assign loadUse  = exMemToReg & (exwsel != '0) & ((exwsel == idrs) | (exwsel == idrt));

  always_ff @(posedge CLK) begin
    if (RST) state <= RUN;
    else     state <= nextState;
  end

  always_comb begin
    nextState = state;
    pcW    = 1'b0;
    ifW    = 1'b0;
    idW    = 1'b0;
    exW    = 1'b0;
    memW   = 1'b0;
    ifRST  = 1'b0;
    idRST  = 1'b0;
    exRST  = 1'b0;
    memRST = 1'b0;
    halted = 1'b0;
    case (state)
      RUN, DWAIT: begin
        nextState = RUN;
        if (dmemPend) begin
          nextState = DWAIT;
        end else if (memcuHALT) begin
          nextState = DRAIN;
          memW  = 1'b1;
          exW   = 1'b1;
          exRST = 1'b1;
        end else if (exBrTaken) begin
          // a taken branch squashes the two younger slots, overriding load-use and icache misses
          pcW   = 1'b1;
          ifW   = 1'b1;
          idW   = 1'b1;
          ifRST = 1'b1;
          idRST = 1'b1;
          exW   = 1'b1;
          memW  = 1'b1;
        end else if (loadUse) begin
          idW   = 1'b1;
          idRST = 1'b1;
          exW   = 1'b1;
          memW  = 1'b1;
        end else if (!ihit) begin
          ifW   = 1'b1;
          ifRST = 1'b1;
          idW   = 1'b1;
          exW   = 1'b1;
          memW  = 1'b1;
        end else begin
          pcW  = 1'b1;
          ifW  = 1'b1;
          idW  = 1'b1;
          exW  = 1'b1;
          memW = 1'b1;
        end
      end
      DRAIN: begin
        memW      = 1'b1;
        nextState = HALTED;
      end
      HALTED: begin
        halted    = 1'b1;
        nextState = HALTED;
      end
      default: nextState = RUN;
    endcase
    // reset clears every pipeline register in the same cycle, whatever the state
    if (RST) begin
      nextState = RUN;
      pcW    = 1'b0;
      ifW    = 1'b1;
      idW    = 1'b1;
      exW    = 1'b1;
      memW   = 1'b1;
      ifRST  = 1'b1;
      idRST  = 1'b1;
      exRST  = 1'b1;
      memRST = 1'b1;
      halted = 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  logic            running;
  logic            evDwait;
  logic            evFlush;
  logic            evStall;
  logic [CNTW-1:0] stallCnt;
  logic [CNTW-1:0] flushCnt;
  logic [CNTW-1:0] dwaitCnt;

  assign running = ((state == RUN) | (state == DWAIT)) & ~RST;
  assign evDwait = running & dmemPend;
  assign evFlush = running & ~dmemPend & ~memcuHALT & exBrTaken;
  assign evStall = running & ~dmemPend & ~memcuHALT & ~exBrTaken & loadUse;

  // saturating event counters; no events occur outside RUN/DWAIT so they freeze once halted
  always_ff @(posedge CLK) begin
    if (RST) begin
      stallCnt <= '0;
      flushCnt <= '0;
      dwaitCnt <= '0;
    end else begin
      if (evStall && (stallCnt != '1)) stallCnt <= stallCnt + 1'b1;
      if (evFlush && (flushCnt != '1)) flushCnt <= flushCnt + 1'b1;
      if (evDwait && (dwaitCnt != '1)) dwaitCnt <= dwaitCnt + 1'b1;
    end
  end

  assign stall_cnt = stallCnt;
  assign flush_cnt = flushCnt;
  assign dwait_cnt = dwaitCnt;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
  assign dwait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a row-priority reference model.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam int REGW = 5;
  localparam int CNTW = 16;

  // output vector order: {pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, halted}
  localparam logic [9:0] V_RESET = 10'b0_1111_1111_0;
  localparam logic [9:0] V_NORM  = 10'b1_1111_0000_0;
  localparam logic [9:0] V_FREEZ = 10'b0_0000_0000_0;
  localparam logic [9:0] V_HALTR = 10'b0_0011_0010_0;
  localparam logic [9:0] V_BRANC = 10'b1_1111_1100_0;
  localparam logic [9:0] V_LDUSE = 10'b0_0111_0100_0;
  localparam logic [9:0] V_IMISS = 10'b0_1111_1000_0;
  localparam logic [9:0] V_DRAIN = 10'b0_0001_0000_0;
  localparam logic [9:0] V_HALTD = 10'b0_0000_0000_1;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic ihit = 1'b0, dhit = 1'b0;
  logic [REGW-1:0] idrs = '0, idrt = '0, exwsel = '0;
  logic exMemToReg = 1'b0, exBrTaken = 1'b0;
  logic memcuDRE = 1'b0, memcuDWE = 1'b0, memcuHALT = 1'b0;
  logic pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, halted;
  logic [CNTW-1:0] stall_cnt, flush_cnt, dwait_cnt;
  logic [9:0] dutVec;

  int total = 0;
  int bad = 0;
  bit checkEn = 1'b0;

  // reference model: only "draining" and "stopped" matter, RUN and DWAIT behave identically
  bit mDrain = 1'b0;
  bit mStopped = 1'b0;
  int mStall = 0, mFlush = 0, mDwait = 0;

  hazard_ctrl #(.REGW(REGW), .CNTW(CNTW)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .idrs(idrs), .idrt(idrt),
    .exwsel(exwsel), .exMemToReg(exMemToReg), .exBrTaken(exBrTaken),
    .memcuDRE(memcuDRE), .memcuDWE(memcuDWE), .memcuHALT(memcuHALT),
    .pcW(pcW), .ifW(ifW), .idW(idW), .exW(exW), .memW(memW),
    .ifRST(ifRST), .idRST(idRST), .exRST(exRST), .memRST(memRST), .halted(halted),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .dwait_cnt(dwait_cnt)
  );

  assign dutVec = {pcW, ifW, idW, exW, memW, ifRST, idRST, exRST, memRST, halted};

  always #5 CLK = ~CLK;

  function automatic int pickRow();
    bit pend;
    bit hazard;
    pend = (memcuDRE || memcuDWE) && !dhit;
    hazard = exMemToReg && (exwsel != 0) && (exwsel == idrs || exwsel == idrt);
    if (pend) return 1;
    if (memcuHALT) return 2;
    if (exBrTaken) return 3;
    if (hazard) return 4;
    if (!ihit) return 5;
    return 6;
  endfunction

  function automatic logic [9:0] modelVec();
    logic [9:0] rowTable [1:6];
    rowTable[1] = V_FREEZ;
    rowTable[2] = V_HALTR;
    rowTable[3] = V_BRANC;
    rowTable[4] = V_LDUSE;
    rowTable[5] = V_IMISS;
    rowTable[6] = V_NORM;
    if (RST) return V_RESET;
    if (mStopped) return V_HALTD;
    if (mDrain) return V_DRAIN;
    return rowTable[pickRow()];
  endfunction

  function automatic int satInc(int v);
    return (v >= 65535) ? 65535 : v + 1;
  endfunction

  task automatic modelStep();
    int row;
    if (RST) begin
      mDrain = 1'b0; mStopped = 1'b0;
      mStall = 0; mFlush = 0; mDwait = 0;
    end else if (mStopped) begin
      mStopped = 1'b1;
    end else if (mDrain) begin
      mDrain = 1'b0; mStopped = 1'b1;
    end else begin
      row = pickRow();
      if (row == 2) mDrain = 1'b1;
      if (PERF && row == 1) mDwait = satInc(mDwait);
      if (PERF && row == 3) mFlush = satInc(mFlush);
      if (PERF && row == 4) mStall = satInc(mStall);
    end
  endtask

  // every-cycle comparison against the model, then advance the model past the coming edge
  always @(negedge CLK) begin
    if (checkEn) begin
      logic [9:0] want;
      want = modelVec();
      total = total + 1;
      if (dutVec !== want) begin
        bad = bad + 1;
        $display("[TB] FAIL model-vec t=%0t got=%b want=%b", $time, dutVec, want);
      end
      total = total + 1;
      if (stall_cnt !== CNTW'(mStall) || flush_cnt !== CNTW'(mFlush) || dwait_cnt !== CNTW'(mDwait)) begin
        bad = bad + 1;
        $display("[TB] FAIL model-cnt t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d", $time,
                 stall_cnt, flush_cnt, dwait_cnt, mStall, mFlush, mDwait);
      end
      modelStep();
    end
  end

  task automatic applyStimulus(input bit r, input bit ih, input bit dh,
                               input int rs, input int rt, input int ws, input bit m2r,
                               input bit br, input bit dre, input bit dwe, input bit hlt);
    @(posedge CLK);
    #1;
    RST = r; ihit = ih; dhit = dh;
    idrs = REGW'(rs); idrt = REGW'(rt); exwsel = REGW'(ws);
    exMemToReg = m2r; exBrTaken = br;
    memcuDRE = dre; memcuDWE = dwe; memcuHALT = hlt;
  endtask

  task automatic checkOutput(input string name, input logic [9:0] want);
    @(negedge CLK);
    total = total + 1;
    if (dutVec !== want) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%b want=%b", name, dutVec, want);
    end
  endtask

  task automatic checkCount(input string name, input logic [CNTW-1:0] got, input int want);
    total = total + 1;
    if (got !== CNTW'(want)) begin
      bad = bad + 1;
      $display("[TB] FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  initial begin
    @(posedge CLK);
    #1;
    checkEn = 1'b1;

    // T1: reset for two cycles, then a clean run
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t1-reset", V_RESET);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t1-run", V_NORM);
    checkCount("t1-stall0", stall_cnt, 0);

    // T2: load-use bubble, then normal; r0 never stalls
    applyStimulus(0, 1, 0, 5, 2, 5, 1, 0, 0, 0, 0); checkOutput("t2-bubble", V_LDUSE);
    applyStimulus(0, 1, 0, 5, 2, 7, 0, 0, 0, 0, 0); checkOutput("t2-after", V_NORM);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0); checkOutput("t2-r0", V_NORM);
    applyStimulus(0, 1, 0, 1, 9, 9, 1, 0, 0, 0, 0); checkOutput("t2-rt", V_LDUSE);

    // T3: branch beats load-use and icache miss
    applyStimulus(0, 0, 0, 5, 0, 5, 1, 1, 0, 0, 0); checkOutput("t3-branch", V_BRANC);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t3-imiss", V_IMISS);
    checkCount("t3-flush", flush_cnt, PERF ? 1 : 0);
    checkCount("t3-stall", stall_cnt, PERF ? 2 : 0);

    // T4: three dmem wait cycles then completion
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0); checkOutput("t4-freeze", V_FREEZ);
    end
    applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0); checkOutput("t4-hit", V_NORM);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t4-run", V_NORM);
    checkCount("t4-dwait", dwait_cnt, PERF ? 3 : 0);

    // T5: halt, drain, stay halted through noise, reset recovers
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1); checkOutput("t5-halt", V_HALTR);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0); checkOutput("t5-drain", V_DRAIN);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(0, i[0], 0, 3, 3, 3, 1, i[1], 1, 0, 1); checkOutput("t5-halted", V_HALTD);
    end
    checkCount("t5-frozen", dwait_cnt, PERF ? 3 : 0);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t5-reset", V_RESET);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t5-run", V_NORM);

    // T6: reset in the middle of a dmem wait
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t6-freeze", V_FREEZ);
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0); checkOutput("t6-reset", V_RESET);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0); checkOutput("t6-run", V_NORM);
    checkCount("t6-dwait0", dwait_cnt, 0);
    checkCount("t6-flush0", flush_cnt, 0);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 80, $urandom_range(1),
                    $urandom_range(3), $urandom_range(3), $urandom_range(3),
                    $urandom_range(1), $urandom_range(99) < 15,
                    $urandom_range(99) < 20, $urandom_range(99) < 15, $urandom_range(99) < 2);
    end

    @(posedge CLK);
    #1;
    checkEn = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
